// File: rtl/rob_multiport_if.sv
// Bundle of dispatch, operand-query, CDB writeback and commit-side signals of the reorder buffer.
// The master side is the pipeline surroundings; the slave side is the ROB itself.
interface rob_multiport_if #(
  parameter int ROB_WIDTH  = 4,
  parameter int CDB_PORTS  = 2,
  parameter int REG_WIDTH  = 5,
  parameter int ADDR_WIDTH = 32
);
  logic                         dp_en;
  logic [1:0]                   dp_type;
  logic [REG_WIDTH-1:0]         dp_rd;
  logic [ADDR_WIDTH-1:0]        dp_pc;
  logic                         dp_pred_taken;
  logic                         rob_full;
  logic [ROB_WIDTH-1:0]         dp_index;

  logic [ROB_WIDTH:0]           qj_index;
  logic [ROB_WIDTH:0]           qk_index;
  logic                         qj_ready;
  logic                         qk_ready;
  logic [31:0]                  vj;
  logic [31:0]                  vk;

  logic [CDB_PORTS-1:0]         cdb_en;
  logic [CDB_PORTS*ROB_WIDTH-1:0]  cdb_index;
  logic [CDB_PORTS*32-1:0]         cdb_value;
  logic [CDB_PORTS*ADDR_WIDTH-1:0] cdb_next_pc;

  logic                         rf_en;
  logic [REG_WIDTH-1:0]         rf_rd;
  logic [ROB_WIDTH-1:0]         rf_index;
  logic [31:0]                  rf_value;
  logic                         st_commit_en;
  logic [ROB_WIDTH-1:0]         st_index;
  logic                         flush;
  logic [ADDR_WIDTH-1:0]        flush_pc;

  modport master (
    output dp_en, dp_type, dp_rd, dp_pc, dp_pred_taken,
    output qj_index, qk_index,
    output cdb_en, cdb_index, cdb_value, cdb_next_pc,
    input  rob_full, dp_index, qj_ready, qk_ready, vj, vk,
    input  rf_en, rf_rd, rf_index, rf_value, st_commit_en, st_index, flush, flush_pc
  );

  modport slave (
    input  dp_en, dp_type, dp_rd, dp_pc, dp_pred_taken,
    input  qj_index, qk_index,
    input  cdb_en, cdb_index, cdb_value, cdb_next_pc,
    output rob_full, dp_index, qj_ready, qk_ready, vj, vk,
    output rf_en, rf_rd, rf_index, rf_value, st_commit_en, st_index, flush, flush_pc
  );
endinterface

// File: rtl/rob_multiport.sv
// Reorder buffer with multi-port CDB writeback, operand bypass and in-order single commit.
// Commits drive RF writes, store releases and pipeline flush/redirect on mispredict or jalr.
module rob_multiport #(
  parameter int ROB_WIDTH  = 4,
  parameter int ROB_SIZE   = 1 << ROB_WIDTH,
  parameter int CDB_PORTS  = 2,
  parameter int REG_WIDTH  = 5,
  parameter int ADDR_WIDTH = 32
) (
  input  logic           Sys_clk,
  input  logic           Sys_rst,
  input  logic           Sys_rdy,
  rob_multiport_if.slave bus
);

  typedef enum logic [1:0] {
    T_ALU  = 2'd0,
    T_BR   = 2'd1,
    T_ST   = 2'd2,
    T_JALR = 2'd3
  } entry_type_e;

  logic [ROB_SIZE-1:0]   busy;
  logic [ROB_SIZE-1:0]   ready;
  logic [ROB_SIZE-1:0]   pred_q;
  entry_type_e           typ_q     [ROB_SIZE];
  logic [REG_WIDTH-1:0]  rd_q      [ROB_SIZE];
  logic [ADDR_WIDTH-1:0] pc_q      [ROB_SIZE];
  logic [31:0]           value_q   [ROB_SIZE];
  logic [ADDR_WIDTH-1:0] next_pc_q [ROB_SIZE];

  logic [ROB_WIDTH-1:0]  head;
  logic [ROB_WIDTH-1:0]  tail;
  logic [ROB_WIDTH:0]    count;

  logic                  rf_en_q;
  logic [REG_WIDTH-1:0]  rf_rd_q;
  logic [ROB_WIDTH-1:0]  rf_index_q;
  logic [31:0]           rf_value_q;
  logic                  st_commit_en_q;
  logic [ROB_WIDTH-1:0]  st_index_q;
  logic                  flush_q;
  logic [ADDR_WIDTH-1:0] flush_pc_q;

  logic [ROB_WIDTH-1:0]  cdb_idx [CDB_PORTS];
  logic [31:0]           cdb_val [CDB_PORTS];
  logic [ADDR_WIDTH-1:0] cdb_npc [CDB_PORTS];

  for (genvar p = 0; p < CDB_PORTS; p++) begin : g_cdb
    assign cdb_idx[p] = bus.cdb_index[p*ROB_WIDTH +: ROB_WIDTH];
    assign cdb_val[p] = bus.cdb_value[p*32 +: 32];
    assign cdb_npc[p] = bus.cdb_next_pc[p*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic full;
  logic do_dispatch;
  logic do_commit;
  logic commit_flush;

  assign full        = (count == (ROB_WIDTH+1)'(ROB_SIZE));
  assign do_dispatch = bus.dp_en && !full;
  assign do_commit   = (count != '0) && busy[head] && ready[head];
  assign commit_flush = do_commit &&
                        ((typ_q[head] == T_JALR) ||
                         ((typ_q[head] == T_BR) && (value_q[head][0] != pred_q[head])));

  assign bus.rob_full = full;
  assign bus.dp_index = tail;

  // Operand lookup: stored result first, else same-cycle CDB bypass (highest port wins).
  logic [ROB_WIDTH:0] q_idx  [2];
  logic               op_rdy [2];
  logic [31:0]        op_val [2];

  assign q_idx[0] = bus.qj_index;
  assign q_idx[1] = bus.qk_index;

  always_comb begin
    for (int unsigned o = 0; o < 2; o++) begin
      op_rdy[o] = 1'b0;
      op_val[o] = '0;
      if (q_idx[o][ROB_WIDTH]) begin
        op_rdy[o] = 1'b1;
      end else if (ready[q_idx[o][ROB_WIDTH-1:0]]) begin
        op_rdy[o] = 1'b1;
        op_val[o] = value_q[q_idx[o][ROB_WIDTH-1:0]];
      end else begin
        for (int unsigned p = 0; p < CDB_PORTS; p++) begin
          if (bus.cdb_en[p] && (cdb_idx[p] == q_idx[o][ROB_WIDTH-1:0])) begin
            op_rdy[o] = 1'b1;
            op_val[o] = cdb_val[p];
          end
        end
      end
    end
  end

  assign bus.qj_ready = op_rdy[0];
  assign bus.vj       = op_val[0];
  assign bus.qk_ready = op_rdy[1];
  assign bus.vk       = op_val[1];

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      ready          <= '0;
      rf_en_q        <= 1'b0;
      rf_rd_q        <= '0;
      rf_index_q     <= '0;
      rf_value_q     <= '0;
      st_commit_en_q <= 1'b0;
      st_index_q     <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      rf_en_q        <= 1'b0;
      st_commit_en_q <= 1'b0;
      flush_q        <= 1'b0;
      if (Sys_rdy) begin
        if (do_commit) begin
          case (typ_q[head])
            T_ALU, T_JALR: begin
              rf_en_q    <= 1'b1;
              rf_rd_q    <= rd_q[head];
              rf_index_q <= head;
              rf_value_q <= value_q[head];
            end
            T_ST: begin
              st_commit_en_q <= 1'b1;
              st_index_q     <= head;
            end
            default: ;
          endcase
          if (commit_flush) begin
            flush_q    <= 1'b1;
            flush_pc_q <= next_pc_q[head];
          end
        end

        if (commit_flush) begin
          // Redirect squashes everything, including this cycle's dispatch and CDB writes.
          busy  <= '0;
          ready <= '0;
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end else begin
          for (int unsigned p = 0; p < CDB_PORTS; p++) begin
            if (bus.cdb_en[p] && busy[cdb_idx[p]]) begin
              ready[cdb_idx[p]]     <= 1'b1;
              value_q[cdb_idx[p]]   <= cdb_val[p];
              next_pc_q[cdb_idx[p]] <= cdb_npc[p];
            end
          end
          if (do_dispatch) begin
            busy[tail]   <= 1'b1;
            ready[tail]  <= 1'b0;
            typ_q[tail]  <= entry_type_e'(bus.dp_type);
            rd_q[tail]   <= bus.dp_rd;
            pc_q[tail]   <= bus.dp_pc;
            pred_q[tail] <= bus.dp_pred_taken;
            tail         <= tail + 1'b1;
          end
          if (do_commit) begin
            busy[head]  <= 1'b0;
            ready[head] <= 1'b0;
            head        <= head + 1'b1;
          end
          count <= count + {{ROB_WIDTH{1'b0}}, do_dispatch} - {{ROB_WIDTH{1'b0}}, do_commit};
        end
      end
    end
  end

  assign bus.rf_en        = rf_en_q;
  assign bus.rf_rd        = rf_rd_q;
  assign bus.rf_index     = rf_index_q;
  assign bus.rf_value     = rf_value_q;
  assign bus.st_commit_en = st_commit_en_q;
  assign bus.st_index     = st_index_q;
  assign bus.flush        = flush_q;
  assign bus.flush_pc     = flush_pc_q;

endmodule
